intr_arb_ctrl: RTL and testbench

INTR_ARB_CTRL -- requirements
Module: intr_arb_ctrl

---
 rtl/intr_arb_ctrl.sv | 145 ++++++++++++++
 tb/tb_intr_arb_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/intr_arb_ctrl.sv
// Interrupt arbiter: per-source gateway FSMs, priority/threshold selection, claim/complete handshake.
// Optional macro INTR_ARB_EDGE_EN selects rising-edge triggering with retrigger capture (default: level).
module intr_arb_ctrl #(
   parameter  int NumSrc = 8,
   parameter  int PrioW  = 3,
   localparam int IdW    = $clog2(NumSrc + 1)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NumSrc-1:0]       intr_src_i,
   input  logic [NumSrc*PrioW-1:0] prio_i,
   input  logic [PrioW-1:0]        threshold_i,
   input  logic                    claim_i,
   output logic [IdW-1:0]          claim_id_o,
   input  logic                    complete_i,
   input  logic [IdW-1:0]          complete_id_i,
   output logic                    irq_o,
   output logic [IdW-1:0]          irq_id_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_CLAIMED = 2'd2
   } gw_state_e;

   gw_state_e         r_state [NumSrc];
   logic [IdW-1:0]    r_irq_id;
   logic              r_irq;
   logic [NumSrc-1:0] w_trig;
   logic [NumSrc-1:0] w_claim_hit;
   logic [NumSrc-1:0] w_cmpl_hit;
   logic [IdW-1:0]    w_best_id;
   logic [PrioW-1:0]  w_best_prio;

`ifdef INTR_ARB_EDGE_EN
   logic [NumSrc-1:0] r_prev;
   logic [NumSrc-1:0] r_retrig;

   assign w_trig = intr_src_i & ~r_prev;

   // Previous-value flops for rising-edge detection.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_prev <= '0;
      end else begin
         r_prev <= intr_src_i;
      end
   end

   // Sticky retrigger: an edge seen while CLAIMED is replayed on complete.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_retrig <= '0;
      end else begin
         for (int i = 0; i < NumSrc; i++) begin
            if (r_state[i] != ST_CLAIMED || w_cmpl_hit[i]) begin
               r_retrig[i] <= 1'b0;
            end else if (w_trig[i]) begin
               r_retrig[i] <= 1'b1;
            end else begin
               r_retrig[i] <= r_retrig[i];
            end
         end
      end
   end
`else
   assign w_trig = intr_src_i;
`endif

   // Decode which gateway the claim and complete strobes address; ID 0 matches nobody.
   always_comb begin
      w_claim_hit = '0;
      w_cmpl_hit  = '0;
      for (int i = 0; i < NumSrc; i++) begin
         w_claim_hit[i] = claim_i    && (r_irq_id      == IdW'(i + 1));
         w_cmpl_hit[i]  = complete_i && (complete_id_i == IdW'(i + 1));
      end
   end

   // Gateway state machines, one per source.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NumSrc; i++) begin
            r_state[i] <= ST_IDLE;
         end
      end else begin
         for (int i = 0; i < NumSrc; i++) begin
            case (r_state[i])
               ST_IDLE: begin
                  if (w_trig[i]) r_state[i] <= ST_PENDING;
               end
               ST_PENDING: begin
                  if (w_claim_hit[i]) r_state[i] <= ST_CLAIMED;
               end
               ST_CLAIMED: begin
`ifdef INTR_ARB_EDGE_EN
                  if (w_cmpl_hit[i]) begin
                     r_state[i] <= (r_retrig[i] || w_trig[i]) ? ST_PENDING : ST_IDLE;
                  end
`else
                  if (w_cmpl_hit[i]) r_state[i] <= ST_IDLE;
`endif
               end
               default: r_state[i] <= ST_IDLE;
            endcase
         end
      end
   end

   // Best eligible source; strict '>' keeps the lowest ID on ties, and the
   // source being claimed this cycle is masked so it never reappears.
   always_comb begin
      w_best_id   = '0;
      w_best_prio = '0;
      for (int i = 0; i < NumSrc; i++) begin
         if (r_state[i] == ST_PENDING && !w_claim_hit[i] &&
             prio_i[i*PrioW +: PrioW] != '0 &&
             prio_i[i*PrioW +: PrioW] > threshold_i &&
             prio_i[i*PrioW +: PrioW] > w_best_prio) begin
            w_best_id   = IdW'(i + 1);
            w_best_prio = prio_i[i*PrioW +: PrioW];
         end else begin
            w_best_id   = w_best_id;
            w_best_prio = w_best_prio;
         end
      end
   end

   // Registered arbitration result.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_irq_id <= '0;
         r_irq    <= 1'b0;
      end else begin
         r_irq_id <= w_best_id;
         r_irq    <= (w_best_id != '0);
      end
   end

   assign irq_id_o   = r_irq_id;
   assign irq_o      = r_irq;
   assign claim_id_o = r_irq_id;

endmodule

// File: tb/tb_intr_arb_ctrl.sv
// Directed self-checking bench for intr_arb_ctrl (NumSrc=8, PrioW=3); edge-mode scenario
// is compiled in only when INTR_ARB_EDGE_EN is defined.
module tb_intr_arb_ctrl;
   localparam int NumSrc = 8;
   localparam int PrioW  = 3;
   localparam int IdW    = 4;

   logic                    clk_i = 1'b0;
   logic                    rst_ni;
   logic [NumSrc-1:0]       intr_src_i;
   logic [NumSrc*PrioW-1:0] prio_i;
   logic [PrioW-1:0]        threshold_i;
   logic                    claim_i;
   logic [IdW-1:0]          claim_id_o;
   logic                    complete_i;
   logic [IdW-1:0]          complete_id_i;
   logic                    irq_o;
   logic [IdW-1:0]          irq_id_o;

   int n_pass  = 0;
   int n_total = 0;

   intr_arb_ctrl #(.NumSrc(NumSrc), .PrioW(PrioW)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .intr_src_i    (intr_src_i),
      .prio_i        (prio_i),
      .threshold_i   (threshold_i),
      .claim_i       (claim_i),
      .claim_id_o    (claim_id_o),
      .complete_i    (complete_i),
      .complete_id_i (complete_id_i),
      .irq_o         (irq_o),
      .irq_id_o      (irq_id_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_prio(input int idx, input logic [PrioW-1:0] val);
      prio_i[idx*PrioW +: PrioW] = val;
   endtask

   task automatic apply_reset();
      rst_ni = 1'b0; intr_src_i = '0; claim_i = 1'b0; complete_i = 1'b0;
      complete_id_i = '0; threshold_i = '0;
      for (int i = 0; i < NumSrc; i++) set_prio(i, 3'd1);
      step(); step();
      rst_ni = 1'b1;
   endtask

   task automatic test_reset_idle();
      apply_reset();
      n_total++; if (irq_id_o !== 4'd0 || irq_o !== 1'b0) $display("FAIL reset_idle irq_id=%0d irq=%0d want 0/0", irq_id_o, irq_o); else n_pass++;
      claim_i = 1'b1;
      n_total++; if (claim_id_o !== 4'd0) $display("FAIL claim_empty claim_id=%0d want 0", claim_id_o); else n_pass++;
      step(); claim_i = 1'b0; step();
      n_total++; if (irq_o !== 1'b0) $display("FAIL claim_empty_after irq=%0d want 0", irq_o); else n_pass++;
   endtask

   task automatic test_basic();
      apply_reset();
      intr_src_i = 8'h04; step(); intr_src_i = 8'h00;
      n_total++; if (irq_id_o !== 4'd0) $display("FAIL basic_lat1 irq_id=%0d want 0", irq_id_o); else n_pass++;
      step();
      n_total++; if (irq_id_o !== 4'd3 || irq_o !== 1'b1) $display("FAIL basic_lat2 irq_id=%0d irq=%0d want 3/1", irq_id_o, irq_o); else n_pass++;
      claim_i = 1'b1;
      n_total++; if (claim_id_o !== 4'd3) $display("FAIL basic_claim claim_id=%0d want 3", claim_id_o); else n_pass++;
      step(); claim_i = 1'b0;
      n_total++; if (irq_o !== 1'b0 || irq_id_o !== 4'd0) $display("FAIL basic_after_claim irq=%0d irq_id=%0d want 0/0", irq_o, irq_id_o); else n_pass++;
   endtask

   task automatic test_priority();
      apply_reset();
      set_prio(1, 3'd2); set_prio(4, 3'd5); set_prio(6, 3'd5);
      intr_src_i = 8'b0101_0010; step(); step();
      n_total++; if (irq_id_o !== 4'd5) $display("FAIL prio_first irq_id=%0d want 5", irq_id_o); else n_pass++;
      claim_i = 1'b1; step(); claim_i = 1'b0;
      n_total++; if (irq_id_o !== 4'd7) $display("FAIL prio_tie irq_id=%0d want 7", irq_id_o); else n_pass++;
      claim_i = 1'b1;
      n_total++; if (claim_id_o !== 4'd7) $display("FAIL prio_claim7 claim_id=%0d want 7", claim_id_o); else n_pass++;
      step(); claim_i = 1'b0;
      n_total++; if (irq_id_o !== 4'd2) $display("FAIL prio_low irq_id=%0d want 2", irq_id_o); else n_pass++;
   endtask

   task automatic test_threshold();
      apply_reset();
      set_prio(0, 3'd3); threshold_i = 3'd3;
      intr_src_i = 8'h01; step(); step(); step();
      n_total++; if (irq_o !== 1'b0) $display("FAIL thr_equal irq=%0d want 0", irq_o); else n_pass++;
      threshold_i = 3'd2; step();
      n_total++; if (irq_id_o !== 4'd1) $display("FAIL thr_below irq_id=%0d want 1", irq_id_o); else n_pass++;
      threshold_i = 3'd7; step();
      n_total++; if (irq_o !== 1'b0) $display("FAIL thr_raise irq=%0d want 0", irq_o); else n_pass++;
      intr_src_i = 8'h00; threshold_i = 3'd2; step();
      n_total++; if (irq_id_o !== 4'd1) $display("FAIL thr_keeps_pending irq_id=%0d want 1", irq_id_o); else n_pass++;
      set_prio(0, 3'd0); threshold_i = 3'd0; step();
      n_total++; if (irq_o !== 1'b0) $display("FAIL prio_zero irq=%0d want 0", irq_o); else n_pass++;
   endtask

   task automatic test_complete();
      apply_reset();
      intr_src_i = 8'h04; step(); step();
      claim_i = 1'b1; step(); claim_i = 1'b0;
      n_total++; if (irq_id_o !== 4'd0) $display("FAIL cmpl_claimed irq_id=%0d want 0", irq_id_o); else n_pass++;
      complete_i = 1'b1; complete_id_i = 4'd5; step(); complete_i = 1'b0; step(); step();
      n_total++; if (irq_id_o !== 4'd0) $display("FAIL cmpl_wrong_id irq_id=%0d want 0", irq_id_o); else n_pass++;
      complete_i = 1'b1; complete_id_i = 4'd3; step(); complete_i = 1'b0; step(); step();
      n_total++; if (irq_id_o !== 4'd3) $display("FAIL cmpl_repend irq_id=%0d want 3", irq_id_o); else n_pass++;
   endtask

   task automatic test_back_to_back();
      apply_reset();
      intr_src_i = 8'h06; step(); step();
      n_total++; if (irq_id_o !== 4'd2) $display("FAIL b2b_first irq_id=%0d want 2", irq_id_o); else n_pass++;
      claim_i = 1'b1; step();
      n_total++; if (claim_id_o !== 4'd3) $display("FAIL b2b_next claim_id=%0d want 3", claim_id_o); else n_pass++;
      complete_i = 1'b1; complete_id_i = 4'd2; step(); claim_i = 1'b0; complete_i = 1'b0;
      n_total++; if (irq_id_o !== 4'd0) $display("FAIL b2b_both irq_id=%0d want 0", irq_id_o); else n_pass++;
      step(); step();
      n_total++; if (irq_id_o !== 4'd2) $display("FAIL b2b_repend irq_id=%0d want 2", irq_id_o); else n_pass++;
   endtask

   task automatic test_reset_midclaim();
      apply_reset();
      set_prio(3, 3'd2); set_prio(5, 3'd1);
      intr_src_i = 8'b0010_1000; step(); step();
      n_total++; if (irq_id_o !== 4'd4) $display("FAIL rst_pre irq_id=%0d want 4", irq_id_o); else n_pass++;
      claim_i = 1'b1; step(); claim_i = 1'b0;
      n_total++; if (irq_id_o !== 4'd6) $display("FAIL rst_pending6 irq_id=%0d want 6", irq_id_o); else n_pass++;
      #2 rst_ni = 1'b0; #1;
      n_total++; if (irq_o !== 1'b0 || irq_id_o !== 4'd0 || claim_id_o !== 4'd0) $display("FAIL rst_async irq=%0d irq_id=%0d claim_id=%0d want 0/0/0", irq_o, irq_id_o, claim_id_o); else n_pass++;
      intr_src_i = 8'h00; step(); rst_ni = 1'b1; step(); step(); step();
      n_total++; if (irq_o !== 1'b0) $display("FAIL rst_release irq=%0d want 0", irq_o); else n_pass++;
      complete_i = 1'b1; complete_id_i = 4'd4; step(); complete_i = 1'b0; step(); step();
      n_total++; if (irq_o !== 1'b0) $display("FAIL rst_claim_dropped irq=%0d want 0", irq_o); else n_pass++;
   endtask

`ifdef INTR_ARB_EDGE_EN
   task automatic test_edge();
      apply_reset();
      intr_src_i = 8'h02; step(); intr_src_i = 8'h00; step();
      n_total++; if (irq_id_o !== 4'd2) $display("FAIL edge_first irq_id=%0d want 2", irq_id_o); else n_pass++;
      claim_i = 1'b1; step(); claim_i = 1'b0;
      intr_src_i = 8'h02; step(); intr_src_i = 8'h00; step();
      n_total++; if (irq_o !== 1'b0) $display("FAIL edge_while_claimed irq=%0d want 0", irq_o); else n_pass++;
      complete_i = 1'b1; complete_id_i = 4'd2; step(); complete_i = 1'b0; step();
      n_total++; if (irq_id_o !== 4'd2) $display("FAIL edge_retrigger irq_id=%0d want 2", irq_id_o); else n_pass++;
      claim_i = 1'b1; step(); claim_i = 1'b0;
      complete_i = 1'b1; complete_id_i = 4'd2; step(); complete_i = 1'b0; step(); step();
      n_total++; if (irq_o !== 1'b0) $display("FAIL edge_no_retrigger irq=%0d want 0", irq_o); else n_pass++;
   endtask
`endif

   initial begin
      rst_ni = 1'b0; intr_src_i = '0; prio_i = '0; threshold_i = '0;
      claim_i = 1'b0; complete_i = 1'b0; complete_id_i = '0;
      test_reset_idle();
      test_basic();
      test_priority();
      test_threshold();
`ifndef INTR_ARB_EDGE_EN
      test_complete();
      test_back_to_back();
`else
      test_edge();
`endif
      test_reset_midclaim();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
